// File: rtl/cordic_polar_iter.sv
// Iterative vectoring-mode CORDIC: converts (x0, y0) into a magnitude and a phase.
// A single add/shift datapath is reused for every micro-rotation.
// Samples are accepted and results delivered over valid/ready handshakes.
module cordic_polar_iter #(
  parameter int width      = 16,
  parameter int iterations = width + 2,
  parameter int guard_bits = iterations - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] x0,
  input  logic signed [width-1:0] y0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [width:0]   mag,
  output logic signed [width-1:0] phase,
  output logic                    busy
);

  localparam int XW = width + guard_bits + 2;
  localparam int ZW = width + guard_bits;
  localparam int CW = $clog2(iterations + 1);

  localparam logic signed [XW-1:0] XONE   = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [ZW-1:0] ZONE   = {{(ZW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] XHALF  = XONE << (guard_bits - 1);
  localparam logic signed [ZW-1:0] ZHALF  = ZONE << (guard_bits - 1);
  localparam logic signed [XW-1:0] MAGMAX = (XONE << (width + 1)) - XONE;
  localparam logic signed [ZW-1:0] ZPI2   = ZONE << (ZW - 2);
  localparam logic        [CW-1:0] ITERS  = CW'(iterations);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state, state_nx;

  logic        [CW-1:0] cnt;
  logic signed [XW-1:0] xr, yr;
  logic signed [ZW-1:0] zr;
  logic                 zero_q;

  logic signed [XW-1:0] xs, ys, xl, yl;
  logic signed [ZW-1:0] zl;
  logic signed [XW-1:0] mag_full;
  logic        [width:0]   mag_nx;
  logic signed [width-1:0] phase_nx;

  // atan(2^-i) in phase units where pi = 2^(ZW-1); atan(1) is exact, the rest use the series
  function automatic logic signed [ZW-1:0] atan_const(input int i);
    real x, xsq, term, sum, scale;
    scale = (2.0 ** (ZW - 1)) / 3.14159265358979323846;
    if (i == 0) begin
      sum = 0.78539816339744830962;
    end else begin
      x = 1.0;
      for (int unsigned k = 0; k < i; k++) x = x / 2.0;
      xsq  = x * x;
      term = x;
      sum  = 0.0;
      for (int unsigned k = 0; k < 40; k++) begin
        if (k % 2 == 0) sum = sum + term / real'(2 * k + 1);
        else            sum = sum - term / real'(2 * k + 1);
        term = term * xsq;
      end
    end
    return ZW'(longint'(sum * scale));
  endfunction

  logic signed [ZW-1:0] atan_tab [iterations];

  for (genvar g = 0; g < iterations; g++) begin : g_atan
    localparam logic signed [ZW-1:0] ATAN_G = atan_const(g);
    assign atan_tab[g] = ATAN_G;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)         state_nx = ITER;
      ITER:    if (cnt == ITERS)     state_nx = DONE;
      DONE:    if (out_ready)        state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Quadrant pre-map: fold the left half-plane onto the right by a +/-90 degree turn
  always_comb begin
    xs = XW'(x0);
    ys = XW'(y0);
    xl = xs;
    yl = ys;
    zl = '0;
    if (x0[width-1]) begin
      if (!y0[width-1]) begin
        xl = ys;
        yl = -xs;
        zl = ZPI2;
      end else begin
        xl = -ys;
        yl = xs;
        zl = -ZPI2;
      end
    end
  end

  // Round away the guard bits; saturate magnitude, let phase wrap
  always_comb begin
    mag_full = (xr + XHALF) >>> guard_bits;
    if (zero_q || mag_full[XW-1]) mag_nx = '0;
    else if (mag_full > MAGMAX)   mag_nx = '1;
    else                          mag_nx = mag_full[width:0];
    phase_nx = zero_q ? '0 : width'((zr + ZHALF) >>> guard_bits);
  end

  // Datapath: load on accept, one micro-rotation per ITER cycle, then one cycle to load outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      zero_q <= 1'b0;
      mag    <= '0;
      phase  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr     <= xl <<< guard_bits;
            yr     <= yl <<< guard_bits;
            zr     <= zl;
            cnt    <= '0;
            zero_q <= (x0 == '0) && (y0 == '0);
          end
        end
        ITER: begin
          // cnt runs one past the last rotation so outputs load from the settled registers
          if (cnt == ITERS) begin
            mag   <= mag_nx;
            phase <= phase_nx;
          end else begin
            if (!yr[XW-1]) begin
              xr <= xr + (yr >>> cnt);
              yr <= yr - (xr >>> cnt);
              zr <= zr + atan_tab[cnt];
            end else begin
              xr <= xr - (yr >>> cnt);
              yr <= yr + (xr >>> cnt);
              zr <= zr - atan_tab[cnt];
            end
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_polar_iter.sv
// Self-checking bench for cordic_polar_iter: directed cases, handshake, reset and a random sweep.
module tb_cordic_polar_iter;

  localparam int  W     = 16;
  localparam int  ITERS = W + 2;
  localparam int  LAT   = ITERS + 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real KG    = 1.6467602581;
  localparam int  MAGSAT = (1 << (W + 1)) - 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] x0 = '0;
  logic signed [W-1:0] y0 = '0;
  logic                in_ready, out_valid, busy;
  logic        [W:0]   mag;
  logic signed [W-1:0] phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_polar_iter #(.width(W), .iterations(ITERS), .guard_bits(ITERS - 1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .out_valid(out_valid), .out_ready(out_ready),
    .mag(mag), .phase(phase), .busy(busy)
  );

  task automatic check(input string tag, input bit ok, input longint obs, input longint exp);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a sample and return at the falling edge right after the accept edge
  task automatic send(input int x, input int y);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_send", in_ready === 1'b1, in_ready, 1);
    x0 = W'(x);
    y0 = W'(y);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x0 = W'($urandom);
    y0 = W'($urandom);
  endtask

  // Count clock edges after the accept edge until out_valid is seen
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", out_valid === 1'b0, out_valid, 0);
    check("drain_in_ready", in_ready === 1'b1, in_ready, 1);
  endtask

  // Compare mag/phase against atan2/hypot
  task automatic check_result(input string tag, input int x, input int y);
    real r, a;
    int  em, ep, d;
    if (x == 0 && y == 0) begin
      check({tag, "_mag"}, mag === '0, mag, 0);
      check({tag, "_phase"}, phase === '0, phase, 0);
    end else begin
      r  = KG * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      a  = $atan2(real'(y), real'(x)) * 32768.0 / PI;
      ep = int'(a);
      if (r > real'(MAGSAT) + 2.0) begin
        check({tag, "_mag_sat"}, int'(mag) == MAGSAT, mag, MAGSAT);
      end else begin
        em = (r > real'(MAGSAT)) ? MAGSAT : int'(r);
        d  = int'(mag) - em;
        check({tag, "_mag"}, d >= -2 && d <= 2, mag, em);
      end
      d = int'(phase) - ep;
      d = ((d % 65536) + 65536 + 32768) % 65536 - 32768;
      if (ep >= 32768) ep -= 65536;
      check({tag, "_phase"}, d >= -2 && d <= 2, phase, ep);
    end
  endtask

  task automatic run_one(input string tag, input int x, input int y);
    int lat;
    send(x, y);
    wait_result(lat);
    check({tag, "_latency"}, lat == LAT, lat, LAT);
    check_result(tag, x, y);
    drain();
  endtask

  int dx [7] = '{10000, 0, -10000, -32768, 0, -10000, 1};
  int dy [7] = '{0, 10000, -10000, -32768, 0, 0, -1};

  initial begin
    int lat, hits, rx, ry;
    logic [W:0]   mag_hold;
    logic [W-1:0] ph_hold;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    check("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    check("rst_busy", busy === 1'b0, busy, 0);
    check("rst_mag", mag === '0, mag, 0);
    check("rst_phase", phase === '0, phase, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_one($sformatf("dir%0d", i), dx[i], dy[i]);

    // Busy pulses ignored, hold with out_ready low, no second result
    send(3000, -7000);
    check("busy_during_iter", busy === 1'b1, busy, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x0 = W'($urandom);
      y0 = W'($urandom);
      @(negedge clk);
      check("in_ready_busy", in_ready === 1'b0, in_ready, 0);
    end
    in_valid = 1'b0;
    wait_result(lat);
    check("hs_latency", lat == LAT - 4, lat + 4, LAT);
    check_result("hs", 3000, -7000);
    mag_hold = mag;
    ph_hold  = phase;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid === 1'b1, out_valid, 1);
      check("hold_in_ready", in_ready === 1'b0, in_ready, 0);
      check("hold_mag", mag === mag_hold, mag, mag_hold);
      check("hold_phase", phase === ph_hold, phase, ph_hold);
    end
    drain();
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    check("no_second_result", hits == 0, hits, 0);

    // Asynchronous reset in the middle of the iterations
    send(20000, 12345);
    repeat (7) @(negedge clk);
    check("mid_busy", busy === 1'b1, busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid === 1'b0, out_valid, 0);
    check("midrst_in_ready", in_ready === 1'b1, in_ready, 1);
    check("midrst_busy", busy === 1'b0, busy, 0);
    check("midrst_mag", mag === '0, mag, 0);
    check("midrst_phase", phase === '0, phase, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_one("post_rst", 0, -5000);

    // Random sweep
    for (int n = 0; n < 2000; n++) begin
      rx = int'($urandom_range(65534)) - 32767;
      ry = int'($urandom_range(65534)) - 32767;
      run_one("rnd", rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
